irq_req_latch4: RTL and testbench

//  Upstream request-capture stage for the 4x2 priority encoder path. Synchronises

---
 rtl/irq_req_latch4.sv | 125 ++++++++++++
 tb/tb_irq_req_latch4.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/irq_req_latch4.sv
// irq_req_latch4: synchronises four request lines, holds each as a sticky
// pending bit and grants the highest-priority pending index through a
// valid/ack handshake. Bit 3 has the highest priority and bit 0 the lowest.
module irq_req_latch4 #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_MODE   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req_in,
  input  logic       ack,
  input  logic       ovf_clr,
  output logic [3:0] pend,
  output logic [1:0] idx,
  output logic       valid,
  output logic [3:0] overflow
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e                        state_q, state_d;
  logic [SYNC_STAGES-1:0][3:0]   sync_q;
  logic [3:0]                    prev_q;
  logic [3:0]                    pend_q, pend_d;
  logic [3:0]                    ovf_q, ovf_d;
  logic [1:0]                    idx_q, idx_d;
  logic [3:0]                    sreq;
  logic [3:0]                    set;
  logic [3:0]                    clr;
  logic [1:0]                    enc_idx;

  assign sreq = sync_q[SYNC_STAGES-1];

  // Synchroniser chain and one-cycle-delayed copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= req_in;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_q[s] <= sync_q[s-1];
      end
      prev_q <= sreq;
    end
  end

  // Set and clear terms for the pending register.
  always_comb begin
    set = '0;
    clr = '0;
    if (EDGE_MODE != 0) begin
      set = sreq & ~prev_q;
    end else begin
      set = sreq;
    end
    for (int i = 0; i < 4; i++) begin
      clr[i] = (state_q == StGrant) && ack && (idx_q == 2'(i));
    end
  end

  // Pending and overflow next state; a set in the ack cycle keeps the bit pending.
  always_comb begin
    pend_d = set | (pend_q & ~clr);
    ovf_d  = ovf_q;
    if (ovf_clr) begin
      ovf_d = '0;
    end else if (EDGE_MODE != 0) begin
      ovf_d = ovf_q | (set & pend_q & ~clr);
    end
  end

  // Priority encoder over the pending bits, bit 3 wins.
  always_comb begin
    enc_idx = 2'd0;
    if (pend_q[3]) begin
      enc_idx = 2'd3;
    end else if (pend_q[2]) begin
      enc_idx = 2'd2;
    end else if (pend_q[1]) begin
      enc_idx = 2'd1;
    end
  end

  // Grant FSM next state; idx is only reloaded on the IDLE->GRANT transition.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StIdle: begin
        if (|pend_q) begin
          state_d = StGrant;
          idx_d   = enc_idx;
        end
      end
      StGrant: begin
        if (ack) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pend_q  <= '0;
      ovf_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign pend     = pend_q;
  assign overflow = ovf_q;
  assign idx      = idx_q;
  assign valid    = (state_q == StGrant);

endmodule

// File: tb/tb_irq_req_latch4.sv
// Bench for irq_req_latch4: edge-mode DUT with a grant scoreboard, plus a
// level-mode DUT exercised directly.
module tb_irq_req_latch4;

  logic       clk = 1'b0;
  logic       rst, ack, ovf_clr;
  logic [3:0] req_in;
  logic [3:0] pend, overflow;
  logic [1:0] idx;
  logic       valid;

  logic       lvl_rst, lvl_ack, lvl_ovf_clr;
  logic [3:0] lvl_req;
  logic [3:0] lvl_pend, lvl_overflow;
  logic [1:0] lvl_idx;
  logic       lvl_valid;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  logic [1:0]  exp_q[$];
  logic        valid_seen = 1'b0;

  always #5 clk = ~clk;

  irq_req_latch4 #(.SYNC_STAGES(2), .EDGE_MODE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .req_in   (req_in),
    .ack      (ack),
    .ovf_clr  (ovf_clr),
    .pend     (pend),
    .idx      (idx),
    .valid    (valid),
    .overflow (overflow)
  );

  irq_req_latch4 #(.SYNC_STAGES(2), .EDGE_MODE(0)) dut_lvl (
    .clk      (clk),
    .rst      (lvl_rst),
    .req_in   (lvl_req),
    .ack      (lvl_ack),
    .ovf_clr  (lvl_ovf_clr),
    .pend     (lvl_pend),
    .idx      (lvl_idx),
    .valid    (lvl_valid),
    .overflow (lvl_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (valid !== 1'b1 && n < 12) begin
      step();
      n++;
    end
    check(tag, {31'd0, valid}, 32'd1);
  endtask

  task automatic do_ack(input string tag, input logic [3:0] exp_pend);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_pend"}, {28'd0, pend}, {28'd0, exp_pend});
  endtask

  // Scoreboard: each new grant must match the oldest expected index.
  always @(negedge clk) begin
    if (rst === 1'b0 && valid === 1'b1 && valid_seen !== 1'b1) begin
      if (exp_q.size() == 0) begin
        check("spurious_grant", {30'd0, idx}, 32'hffff_ffff);
      end else begin
        check("grant_idx", {30'd0, idx}, {30'd0, exp_q.pop_front()});
      end
    end
    valid_seen = valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; ack = 1'b0; ovf_clr = 1'b0; req_in = 4'b0;
    lvl_rst = 1'b1; lvl_ack = 1'b0; lvl_ovf_clr = 1'b0; lvl_req = 4'b0;

    // 1: reset with requests low
    repeat (3) step();
    check("rst_pend", {28'd0, pend}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_idx", {30'd0, idx}, 32'd0);
    check("rst_ovf", {28'd0, overflow}, 32'd0);
    rst = 1'b0;
    lvl_rst = 1'b0;

    // 2: single request, latency and ack
    req_in = 4'b0100;
    exp_q.push_back(2'd2);
    step(); step(); step();
    check("t2_pend_k2", {28'd0, pend}, 32'h4);
    check("t2_valid_k2", {31'd0, valid}, 32'd0);
    step();
    check("t2_valid_k3", {31'd0, valid}, 32'd1);
    check("t2_idx_k3", {30'd0, idx}, 32'd2);
    req_in = 4'b0;
    do_ack("t2_ack", 4'b0000);
    repeat (4) step();

    // 3: three simultaneous requests, priority order with one-cycle bubbles
    req_in = 4'b1011;
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    step(); step(); step();
    check("t3_pend", {28'd0, pend}, 32'hb);
    step();
    check("t3_valid0", {31'd0, valid}, 32'd1);
    do_ack("t3_ack3", 4'b0011);
    step();
    check("t3_valid1", {31'd0, valid}, 32'd1);
    do_ack("t3_ack1", 4'b0001);
    step();
    check("t3_valid2", {31'd0, valid}, 32'd1);
    do_ack("t3_ack0", 4'b0000);
    req_in = 4'b0;
    repeat (4) step();

    // 4: higher-priority arrival during grant does not disturb idx
    req_in = 4'b0010;
    exp_q.push_back(2'd1);
    wait_grant("t4_grant1");
    req_in = 4'b1010;
    exp_q.push_back(2'd3);
    step(); step(); step();
    check("t4_pend", {28'd0, pend}, 32'ha);
    check("t4_idx_hold", {30'd0, idx}, 32'd1);
    check("t4_valid_hold", {31'd0, valid}, 32'd1);
    do_ack("t4_ack1", 4'b1000);
    wait_grant("t4_grant3");
    do_ack("t4_ack3", 4'b0000);
    req_in = 4'b0;
    repeat (4) step();

    // 5: overflow on a second edge, clear, and edge coincident with ack
    req_in = 4'b0001;
    exp_q.push_back(2'd0);
    wait_grant("t5_grant0");
    req_in = 4'b0;
    repeat (3) step();
    req_in = 4'b0001;
    repeat (3) step();
    req_in = 4'b0;
    check("t5_ovf_set", {28'd0, overflow}, 32'h1);
    check("t5_pend", {28'd0, pend}, 32'h1);
    check("t5_valid", {31'd0, valid}, 32'd1);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("t5_ovf_clr", {28'd0, overflow}, 32'h0);
    step(); step();
    req_in = 4'b0001;
    exp_q.push_back(2'd0);
    step(); step();
    do_ack("t5_ack_coinc", 4'b0001);
    check("t5_ovf_coinc", {28'd0, overflow}, 32'h0);
    req_in = 4'b0;
    wait_grant("t5_regrant");
    do_ack("t5_ack_final", 4'b0000);
    check("t5_ovf_final", {28'd0, overflow}, 32'h0);
    repeat (4) step();

    // 6a: reset during grant drops everything pending
    req_in = 4'b0100;
    exp_q.push_back(2'd2);
    wait_grant("t6_grant");
    req_in = 4'b0001;
    step(); step(); step();
    check("t6_pend_pre", {28'd0, pend}, 32'h5);
    req_in = 4'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_valid", {31'd0, valid}, 32'd0);
    check("t6_rst_pend", {28'd0, pend}, 32'h0);
    check("t6_rst_idx", {30'd0, idx}, 32'd0);
    repeat (4) step();
    check("t6_no_regrant", {31'd0, valid}, 32'd0);

    // 6b: level mode, held request re-granted after every ack, no overflow
    lvl_req = 4'b0100;
    step(); step(); step(); step();
    for (int r = 0; r < 3; r++) begin
      check("lvl_valid", {31'd0, lvl_valid}, 32'd1);
      check("lvl_idx", {30'd0, lvl_idx}, 32'd2);
      lvl_ack = 1'b1;
      step();
      lvl_ack = 1'b0;
      check("lvl_bubble", {31'd0, lvl_valid}, 32'd0);
      check("lvl_pend", {28'd0, lvl_pend}, 32'h4);
      step();
    end
    check("lvl_ovf", {28'd0, lvl_overflow}, 32'h0);
    lvl_req = 4'b0;

    step();
    check("sb_empty", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
